// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO stream reader slice.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_t;

  localparam int RD_BUF_DEPTH = 2;
  localparam int RD_OCC_W     = $clog2(RD_BUF_DEPTH + 1);

endpackage

// File: rtl/out_skid_buf.sv
// Two-entry output buffer: head entry drives the stream, pushes land at the tail.
module out_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic                i_pop,
  input  logic                i_clear,
  input  logic [WIDTH-1:0]    i_data,
  output logic [WIDTH-1:0]    o_data,
  output logic [RD_OCC_W-1:0] o_occ
);

  logic [WIDTH-1:0]    r_mem [RD_BUF_DEPTH];
  logic                r_head;
  logic [RD_OCC_W-1:0] r_occ;
  logic                w_tail;

  // With two slots the tail is head when occ is 0 or 2, the other slot when occ is 1;
  // at occ==2 a push only happens together with a pop, so it refills the slot being vacated.
  assign w_tail = r_head ^ r_occ[0];
  assign o_data = r_mem[r_head];
  assign o_occ  = r_occ;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (i_push && !i_clear) r_mem[w_tail] <= i_data;
      if (i_clear) begin
        r_occ <= '0;
      end else begin
        if (i_pop) r_head <= ~r_head;
        case ({i_push, i_pop})
          2'b10:   r_occ <= r_occ + RD_OCC_W'(1);
          2'b01:   r_occ <= r_occ - RD_OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// FIFO consumer: pops the FIFO into a 2-entry buffer and presents a valid/ready stream.
// Optional macro FIFO_STREAM_READER_ASSERT_EN compiles in protocol assertions and covers.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic             flush_done
);

  rd_state_t           r_state;
  logic [CNT_W-1:0]    r_word_cnt;
  logic                r_flush_done;
  logic [RD_OCC_W-1:0] w_occ;
  logic                w_fire;
  logic                w_push;
  logic                w_clear;
  logic                w_has_room;

  out_skid_buf #(
    .WIDTH (WIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_fire),
    .i_clear (w_clear),
    .i_data  (fifo_data),
    .o_data  (out_data),
    .o_occ   (w_occ)
  );

  assign out_valid  = (w_occ != '0);
  assign w_fire     = out_valid & out_ready;
  assign w_has_room = (w_occ < RD_OCC_W'(RD_BUF_DEPTH)) | w_fire;

  always_comb begin
    fifo_pop = 1'b0;
    case (r_state)
      RUN:     fifo_pop = !fifo_empty && w_has_room;
      FLUSH:   fifo_pop = !fifo_empty;
      default: fifo_pop = 1'b0;
    endcase
  end

  // FLUSH pops are discarded: only RUN pops reach the buffer.
  assign w_push  = fifo_pop && (r_state == RUN);
  assign w_clear = flush && (r_state != FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_flush_done <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush)       r_state <= FLUSH;
          else if (enable) r_state <= RUN;
        end
        RUN: begin
          if (flush)        r_state <= FLUSH;
          else if (!enable) r_state <= IDLE;
        end
        FLUSH: begin
          if (fifo_empty && !flush) begin
            r_state      <= IDLE;
            r_flush_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt <= '0;
    end else if (w_fire && (r_word_cnt != '1)) begin
      r_word_cnt <= r_word_cnt + CNT_W'(1);
    end
  end

  assign word_cnt   = r_word_cnt;
  assign flush_done = r_flush_done;
  assign busy       = (r_state != IDLE) || out_valid;

`ifdef FIFO_STREAM_READER_ASSERT_EN
  a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst)
    fifo_pop |-> !fifo_empty);

  // A flush is the one sanctioned way for a stalled word to vanish.
  a_stall_hold: assert property (@(posedge clk) disable iff (!rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst)
    w_occ <= RD_OCC_W'(RD_BUF_DEPTH));

  a_flush_quiet: assert property (@(posedge clk) disable iff (!rst)
    (r_state == FLUSH) |-> !out_valid);

  c_buf_full:   cover property (@(posedge clk) disable iff (!rst) w_occ == RD_OCC_W'(RD_BUF_DEPTH));
  c_fire_pop:   cover property (@(posedge clk) disable iff (!rst) w_fire && fifo_pop);
  c_flush_done: cover property (@(posedge clk) disable iff (!rst) flush_done);
`endif

endmodule
